branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 119 +++++++++++
 tb/tb_branch_predictor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_predictor                                                |
// | Purpose  : Direct-mapped branch target buffer with 2-bit saturating        |
// |            counters. Fetch-stage lookup is combinational from the table;   |
// |            the table is trained from the execute stage one edge after      |
// |            UpdateE is sampled high. Also computes the EX-stage redirect    |
// |            request and keeps branch / mispredict performance counters.     |
// | Ports    : clk, rst_n           clock, async active-low reset             |
// |            PCF                  fetch PC to look up                       |
// |            PredTakenF/TargetF   fetch-stage prediction                    |
// |            UpdateE, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE       |
// |                                 resolved branch and its earlier prediction|
// |            MispredictE          redirect request (combinational)          |
// |            BranchCount/MissCount performance counters (wrap at 2^32)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        UpdateE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  localparam logic [1:0] c_ctr_reset = 2'b01;
  localparam logic [1:0] c_ctr_alloc = 2'b10;
  localparam logic [1:0] c_ctr_max   = 2'b11;
  localparam logic [1:0] c_ctr_min   = 2'b00;

  logic            r_valid  [ENTRIES];
  logic [TAGW-1:0] r_tag    [ENTRIES];
  logic [31:0]     r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];
  logic [31:0]     r_bcnt;
  logic [31:0]     r_mcnt;

  logic [IDX-1:0]  w_idx_f;
  logic [TAGW-1:0] w_tag_f;
  logic            w_hit_f;
  logic [IDX-1:0]  w_idx_e;
  logic [TAGW-1:0] w_tag_e;
  logic            w_hit_e;
  logic            w_unused_bits;

  // Byte-offset bits take no part in indexing or tagging.
  assign w_unused_bits = ^{PCF[1:0], PCE[1:0]};

  assign w_idx_f = PCF[IDX+1:2];
  assign w_tag_f = PCF[31:IDX+2];
  assign w_idx_e = PCE[IDX+1:2];
  assign w_tag_e = PCE[31:IDX+2];

  // Lookup reads the registered table only, so a same-cycle update to the
  // same index is not bypassed; the new contents appear after the edge.
  assign w_hit_f     = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign PredTakenF  = w_hit_f && r_ctr[w_idx_f][1];
  assign PredTargetF = PredTakenF ? r_target[w_idx_f] : (PCF + 32'd4);

  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

  assign MispredictE = UpdateE &&
                       ((PredTakenE != BranchE) ||
                        (PredTakenE && BranchE && (PredTargetE != BrTargetE)));

  assign BranchCount = r_bcnt;
  assign MissCount   = r_mcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
        r_ctr[i]    <= c_ctr_reset;
      end
      r_bcnt <= 32'd0;
      r_mcnt <= 32'd0;
    end else if (UpdateE) begin
      r_bcnt <= r_bcnt + 32'd1;
      if (MispredictE) begin
        r_mcnt <= r_mcnt + 32'd1;
      end
      if (w_hit_e) begin
        if (BranchE) begin
          r_target[w_idx_e] <= BrTargetE;
          if (r_ctr[w_idx_e] != c_ctr_max) begin
            r_ctr[w_idx_e] <= r_ctr[w_idx_e] + 2'd1;
          end
        end else if (r_ctr[w_idx_e] != c_ctr_min) begin
          r_ctr[w_idx_e] <= r_ctr[w_idx_e] - 2'd1;
        end
      end else if (BranchE) begin
        // Only taken branches earn a table slot; allocation replaces any
        // aliasing entry and starts weakly taken.
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= BrTargetE;
        r_ctr[w_idx_e]    <= c_ctr_alloc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_branch_predictor                                             |
// | Purpose  : Self-checking bench for branch_predictor. A driver applies one  |
// |            stimulus per cycle and pushes the expected response, computed   |
// |            from a behavioural table model, into a queue; a monitor pops    |
// |            and compares on the falling edge.                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_branch_predictor;

  localparam int ENT = 16;
  localparam int TSH = $clog2(ENT) + 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateE;
  logic [31:0] PCE;
  logic        BranchE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] BranchCount;
  logic [31:0] MissCount;

  branch_predictor #(.ENTRIES(ENT)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .UpdateE(UpdateE), .PCE(PCE),
    .BranchE(BranchE), .BrTargetE(BrTargetE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .MispredictE(MispredictE),
    .BranchCount(BranchCount), .MissCount(MissCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model: each slot remembers which PC (word address) owns it,
  // its target and a confidence level 0..3.
  bit          m_valid [ENT];
  int unsigned m_owner [ENT];
  logic [31:0] m_target[ENT];
  int          m_conf  [ENT];
  logic [31:0] m_bcnt, m_mcnt;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic int unsigned owner(input logic [31:0] pc);
    return pc >> TSH;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && m_owner[slot(pc)] == owner(pc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_owner[i] = 0; m_target[i] = 0; m_conf[i] = 1;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  function automatic bit model_mis(input bit upd, input bit pte, input bit br,
                                   input logic [31:0] ptg, input logic [31:0] brt);
    if (!upd) return 0;
    if (pte != br) return 1;
    return pte && br && ptg != brt;
  endfunction

  // Apply the branch currently on the EX inputs, as the DUT does at this edge.
  task automatic model_commit();
    int s;
    if (!rst_n || !UpdateE) return;
    s = slot(PCE);
    m_bcnt = m_bcnt + 1;
    if (model_mis(UpdateE, PredTakenE, BranchE, PredTargetE, BrTargetE))
      m_mcnt = m_mcnt + 1;
    if (m_hit(PCE)) begin
      if (BranchE) begin
        m_target[s] = BrTargetE;
        m_conf[s]   = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
      end else begin
        m_conf[s]   = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
      end
    end else if (BranchE) begin
      m_valid[s] = 1; m_owner[s] = owner(PCE); m_target[s] = BrTargetE; m_conf[s] = 2;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // One cycle of stimulus: commit the branch sampled at this edge into the
  // model, drive the next inputs and queue the response they should produce.
  task automatic cycle(input bit upd, input logic [31:0] pce, input bit br,
                       input logic [31:0] brt, input bit pte, input logic [31:0] ptg,
                       input logic [31:0] pcf);
    exp_t e;
    @(posedge clk);
    model_commit();
    #1;
    UpdateE = upd; PCE = pce; BranchE = br; BrTargetE = brt;
    PredTakenE = pte; PredTargetE = ptg; PCF = pcf;
    e.taken  = m_hit(pcf) && m_conf[slot(pcf)] >= 2;
    e.target = e.taken ? m_target[slot(pcf)] : pcf + 32'd4;
    e.mis    = model_mis(upd, pte, br, ptg, brt);
    e.bcnt   = m_bcnt;
    e.mcnt   = m_mcnt;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; compare whenever an expectation
  // is outstanding.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("PredTakenF",  {31'd0, PredTakenF},  {31'd0, e.taken});
        check("PredTargetF", PredTargetF,          e.target);
        check("MispredictE", {31'd0, MispredictE}, {31'd0, e.mis});
        check("BranchCount", BranchCount,          e.bcnt);
        check("MissCount",   MissCount,            e.mcnt);
      end
    end
  end

  logic [31:0] pool [8];

  initial begin
    pool = '{32'h40, 32'h80, 32'hC0, 32'h44, 32'h1040, 32'h100, 32'h2000, 32'h48};
    rst_n = 1'b0; UpdateE = 0; PCE = 0; BranchE = 0; BrTargetE = 0;
    PredTakenE = 0; PredTargetE = 0; PCF = 32'h40;
    model_reset();
    #2;
    check("reset_taken",  {31'd0, PredTakenF}, 32'd0);
    check("reset_target", PredTargetF, 32'h44);
    check("reset_bcnt",   BranchCount, 32'd0);
    check("reset_mcnt",   MissCount,   32'd0);
    #20;
    rst_n = 1'b1;

    // Lookup after reset, then allocate 0x40 -> 0x100.
    cycle(0, 0,     0, 0,      0, 0,      32'h40);
    cycle(1, 32'h40, 1, 32'h100, 0, 32'h44, 32'h40);
    cycle(0, 0,     0, 0,      0, 0,      32'h40);
    // Not-taken three times, then four taken (saturation both ways).
    for (int i = 0; i < 3; i++) cycle(1, 32'h40, 0, 0, 1, 32'h100, 32'h40);
    for (int i = 0; i < 4; i++) cycle(1, 32'h41, 1, 32'h100, 0, 32'h44, 32'h43);
    // Target change with concurrent lookup still seeing the old target.
    cycle(1, 32'h40, 1, 32'h200, 1, 32'h100, 32'h40);
    cycle(0, 0,     0, 0,      0, 0,      32'h40);
    // Alias: 0x80 replaces 0x40; a not-taken miss at 0x40 leaves it alone.
    cycle(1, 32'h80, 1, 32'h300, 0, 32'h84, 32'h80);
    cycle(1, 32'h40, 0, 0,      0, 32'h44, 32'h40);
    cycle(0, 0,     0, 0,      0, 0,      32'h80);
    cycle(0, 0,     0, 0,      0, 0,      32'h40);

    // Randomised traffic over a small PC pool so entries hit and alias.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pe, pf, bt, pt;
      pe = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      pf = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      bt = 32'($urandom_range(1, 4)) << 8;
      pt = ($urandom_range(0, 1) == 1) ? bt : (32'($urandom_range(1, 4)) << 8);
      cycle(($urandom_range(0, 3) != 0), pe, $urandom_range(0, 1) == 1, bt,
            $urandom_range(0, 1) == 1, pt, pf);
    end

    // Asynchronous reset between edges while an update is pending.
    cycle(1, 32'h40, 1, 32'h500, 0, 32'h44, 32'h40);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_taken",  {31'd0, PredTakenF}, 32'd0);
    check("async_target", PredTargetF, 32'h44);
    check("async_bcnt",   BranchCount, 32'd0);
    check("async_mcnt",   MissCount,   32'd0);
    model_reset();
    UpdateE = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cycle(0, 0,     0, 0,      0, 0,      32'h40);
    cycle(0, 0,     0, 0,      0, 0,      32'h80);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
